// File: rtl/operand_fetch.sv
// Operand-fetch stage: presents register file read addresses on accept, captures
// the registered read data one cycle later with writeback forwarding, and holds it.
module operand_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4+3*ADDR_WIDTH-1:0]   instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic [ADDR_WIDTH-1:0]       r1_addr,
  output logic [ADDR_WIDTH-1:0]       r2_addr,
  input  logic [DATA_WIDTH-1:0]       r1_data,
  input  logic [DATA_WIDTH-1:0]       r2_data,
  input  logic                        wb_valid,
  input  logic [ADDR_WIDTH-1:0]       wb_addr,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        flush,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [3:0]                  op_opcode,
  output logic [ADDR_WIDTH-1:0]       op_rd,
  output logic [DATA_WIDTH-1:0]       op_a,
  output logic [DATA_WIDTH-1:0]       op_b
);
  // state | meaning
  // IDLE  | no instruction held, ready to accept
  // READ  | read addresses presented last cycle, register file data returns now
  // OUT   | operands valid downstream, waiting for op_ready
  localparam int IW = 4 + 3*ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, OUT = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic                    accept, capture, hold_upd;
  logic [3:0]              opcode_q;
  logic [ADDR_WIDTH-1:0]   rd_q, rs1_q, rs2_q;
  logic [3:0]              instr_op;
  logic [ADDR_WIDTH-1:0]   instr_rd, instr_rs1, instr_rs2;
  logic                    hit1, hit2;

  assign instr_op  = instr[IW-1 -: 4];
  assign instr_rd  = instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign instr_rs1 = instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign instr_rs2 = instr[ADDR_WIDTH-1:0];

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] rs);
    return ZERO_REG && (rs == '0);
  endfunction

  // Register index 0 wins over a writeback to it; a same-cycle writeback wins over stale read data.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0] d,
    input logic                  wv,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wd
  );
    if (is_zero(rs))          return '0;
    else if (wv && wa == rs)  return wd;
    else                      return d;
  endfunction

  assign hit1     = wb_valid && (wb_addr == rs1_q) && !is_zero(rs1_q);
  assign hit2     = wb_valid && (wb_addr == rs2_q) && !is_zero(rs2_q);
  assign op_valid = (state == OUT);
  assign r1_addr  = accept ? instr_rs1 : rs1_q;
  assign r2_addr  = accept ? instr_rs2 : rs2_q;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    capture     = 1'b0;
    hold_upd    = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      READ: begin
        capture   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        instr_ready = op_ready;
        hold_upd    = 1'b1;
        if (op_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      instr_ready = 1'b0;
      capture     = 1'b0;
      hold_upd    = 1'b0;
      state_nxt   = IDLE;
    end
    accept = instr_valid && instr_ready;
    if (accept) state_nxt = READ;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_opcode <= '0;
      op_rd     <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opcode_q <= instr_op;
        rd_q     <= instr_rd;
        rs1_q    <= instr_rs1;
        rs2_q    <= instr_rs2;
      end
      if (capture) begin
        op_opcode <= opcode_q;
        op_rd     <= rd_q;
        op_a      <= fwd(rs1_q, r1_data, wb_valid, wb_addr, wb_data);
        op_b      <= fwd(rs2_q, r2_data, wb_valid, wb_addr, wb_data);
      end else if (hold_upd) begin
        // Held operands track writebacks so a stalled consumer never sees stale data.
        if (hit1) op_a <= wb_data;
        if (hit2) op_b <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: write-first register file model, vector table,
// and a scoreboard queue popped on each downstream handshake.
module tb_operand_fetch;
  logic        clock, reset, preload;
  logic [15:0] instr;
  logic        instr_valid, instr_ready;
  logic [3:0]  r1_addr, r2_addr, wb_addr;
  logic [7:0]  r1_data, r2_data, wb_data;
  logic        wb_valid, flush, op_valid, op_ready;
  logic [3:0]  op_opcode, op_rd;
  logic [7:0]  op_a, op_b;

  operand_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(r1_data), .r2_data(r2_data), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
    .op_opcode(op_opcode), .op_rd(op_rd), .op_a(op_a), .op_b(op_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] regs [16];
  always @(posedge clock) begin
    r1_data <= (wb_valid && wb_addr == r1_addr) ? wb_data : regs[r1_addr];
    r2_data <= (wb_valid && wb_addr == r2_addr) ? wb_data : regs[r2_addr];
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'(8'h40 + i);
      regs[3] <= 8'h11;
      regs[5] <= 8'h22;
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  typedef struct {
    logic [3:0] op, rd, rs1, rs2;
    bit         wb_en;
    logic [3:0] wb_a;
    logic [7:0] wb_d, exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [3:0] op, rd;
    logic [7:0] a, b;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   pops = 0;
  int   pushes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] enc(input vec_t v);
    return {v.op, v.rd, v.rs1, v.rs2};
  endfunction

  task automatic push(input vec_t v);
    sb.push_back('{v.op, v.rd, v.exp_a, v.exp_b});
    pushes++;
  endtask

  always begin
    @(negedge clock);
    #1;
    if (op_valid === 1'b1 && op_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_op: got op_valid with opcode 0x%0h, expected none", op_opcode);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        chk("op_opcode", 32'(op_opcode), 32'(e.op));
        chk("op_rd",     32'(op_rd),     32'(e.rd));
        chk("op_a",      32'(op_a),      32'(e.a));
        chk("op_b",      32'(op_b),      32'(e.b));
      end
    end
  end

  // Single instruction with op_ready=1: accept, READ (optional writeback), OUT.
  task automatic apply_vec(input vec_t v);
    @(negedge clock);
    instr = enc(v);
    instr_valid = 1'b1;
    #1;
    chk("instr_ready_accept", 32'(instr_ready), 32'd1);
    chk("r1_addr", 32'(r1_addr), 32'(v.rs1));
    chk("r2_addr", 32'(r2_addr), 32'(v.rs2));
    push(v);
    @(negedge clock);
    instr_valid = 1'b0;
    wb_valid = v.wb_en;
    wb_addr  = v.wb_a;
    wb_data  = v.wb_d;
    #1;
    chk("op_valid_read", 32'(op_valid), 32'd0);
    chk("instr_ready_read", 32'(instr_ready), 32'd0);
    @(negedge clock);
    wb_valid = 1'b0;
    #1;
    chk("op_valid_latency", 32'(op_valid), 32'd1);
  endtask

  vec_t vecs[9];
  vec_t b2b[4];
  vec_t after_flush, after_reset;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd2,  4'd1,  4'd3,  4'd5,  1'b0, 4'd0,  8'h00, 8'h11, 8'h22};
    vecs[1] = '{4'd3,  4'd2,  4'd3,  4'd5,  1'b1, 4'd3,  8'h7F, 8'h7F, 8'h22};
    vecs[2] = '{4'd4,  4'd3,  4'd0,  4'd0,  1'b1, 4'd0,  8'hAA, 8'h00, 8'h00};
    vecs[3] = '{4'd5,  4'd4,  4'd7,  4'd7,  1'b1, 4'd7,  8'h5C, 8'h5C, 8'h5C};
    vecs[4] = '{4'd6,  4'd5,  4'd3,  4'd9,  1'b0, 4'd0,  8'h00, 8'h7F, 8'h49};
    vecs[5] = '{4'd7,  4'd6,  4'd9,  4'd0,  1'b1, 4'd9,  8'h01, 8'h01, 8'h00};
    vecs[6] = '{4'd15, 4'd15, 4'd15, 4'd14, 1'b1, 4'd14, 8'hEE, 8'h4F, 8'hEE};
    vecs[7] = '{4'd0,  4'd0,  4'd0,  4'd9,  1'b0, 4'd0,  8'h00, 8'h00, 8'h01};
    vecs[8] = '{4'd1,  4'd7,  4'd12, 4'd3,  1'b1, 4'd5,  8'h99, 8'h4C, 8'h7F};
    b2b[0]  = '{4'd10, 4'd1,  4'd1,  4'd2,  1'b0, 4'd0,  8'h00, 8'h41, 8'h42};
    b2b[1]  = '{4'd11, 4'd2,  4'd3,  4'd4,  1'b0, 4'd0,  8'h00, 8'h7F, 8'h44};
    b2b[2]  = '{4'd12, 4'd3,  4'd5,  4'd6,  1'b0, 4'd0,  8'h00, 8'h33, 8'h46};
    b2b[3]  = '{4'd13, 4'd4,  4'd7,  4'd8,  1'b0, 4'd0,  8'h00, 8'h5C, 8'h48};
    after_flush = '{4'd8, 4'd8,  4'd6, 4'd3,  1'b0, 4'd0, 8'h00, 8'h46, 8'h7F};
    after_reset = '{4'd3, 4'd12, 4'd4, 4'd14, 1'b0, 4'd0, 8'h00, 8'h44, 8'hEE};

    reset = 1'b1; preload = 1'b1; instr = '0; instr_valid = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; op_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0; preload = 1'b0;
    #1;
    chk("rst_op_valid",    32'(op_valid),    32'd0);
    chk("rst_op_opcode",   32'(op_opcode),   32'd0);
    chk("rst_op_rd",       32'(op_rd),       32'd0);
    chk("rst_op_a",        32'(op_a),        32'd0);
    chk("rst_op_b",        32'(op_b),        32'd0);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_r1_addr",     32'(r1_addr),     32'd0);
    chk("rst_r2_addr",     32'(r2_addr),     32'd0);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Stall for four cycles; a writeback to rs2 lands on the held operand.
    @(negedge clock);
    op_ready = 1'b0;
    instr = 16'h9A35;
    instr_valid = 1'b1;
    #1;
    chk("hold_accept", 32'(instr_ready), 32'd1);
    sb.push_back('{4'd9, 4'd10, 8'h7F, 8'h33});
    pushes++;
    @(negedge clock);
    instr_valid = 1'b0;
    for (int h = 0; h < 4; h++) begin
      @(negedge clock);
      wb_valid = (h == 1);
      wb_addr  = 4'd5;
      wb_data  = 8'h33;
      #1;
      chk("hold_op_valid",    32'(op_valid),    32'd1);
      chk("hold_instr_ready", 32'(instr_ready), 32'd0);
      chk("hold_opcode",      32'(op_opcode),   32'd9);
      chk("hold_rd",          32'(op_rd),       32'd10);
      chk("hold_a",           32'(op_a),        32'h7F);
      chk("hold_b",           32'(op_b),        (h < 2) ? 32'h99 : 32'h33);
    end
    @(negedge clock);
    wb_valid = 1'b0;
    op_ready = 1'b1;
    @(negedge clock);

    // Back-to-back stream: one accept every two cycles.
    begin
      int k = 0;
      int cyc = 0;
      int last = -1;
      instr = enc(b2b[0]);
      instr_valid = 1'b1;
      while (k < 4 && cyc < 40) begin
        #1;
        if (instr_ready) begin
          if (k > 0) chk("b2b_interval", 32'(cyc - last), 32'd2);
          chk("b2b_r1_addr", 32'(r1_addr), 32'(b2b[k].rs1));
          last = cyc;
          push(b2b[k]);
          @(negedge clock);
          cyc++;
          k++;
          if (k < 4) instr = enc(b2b[k]);
          else instr_valid = 1'b0;
        end else begin
          @(negedge clock);
          cyc++;
        end
      end
      chk("b2b_accepts", 32'(k), 32'd4);
      instr_valid = 1'b0;
      repeat (3) @(negedge clock);
    end

    // Flush while in READ: instruction dropped, data registers keep last values.
    instr = 16'h5912;
    instr_valid = 1'b1;
    #1;
    chk("flush_pre_accept", 32'(instr_ready), 32'd1);
    @(negedge clock);
    instr_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_instr_ready", 32'(instr_ready), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush_op_valid", 32'(op_valid),    32'd0);
    chk("flush_keep_op",  32'(op_opcode),   32'd13);
    chk("flush_keep_a",   32'(op_a),        32'h5C);
    chk("flush_idle",     32'(instr_ready), 32'd1);
    // Flush in IDLE blocks acceptance.
    @(negedge clock);
    instr = 16'h6666;
    instr_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", 32'(instr_ready), 32'd0);
    @(negedge clock);
    instr_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    #1;
    chk("flush_no_accept", 32'(op_valid), 32'd0);
    apply_vec(after_flush);

    // Reset while in OUT: no output pulse, registers cleared.
    @(negedge clock);
    op_ready = 1'b0;
    instr = 16'h4444;
    instr_valid = 1'b1;
    #1;
    chk("rst_mid_accept", 32'(instr_ready), 32'd1);
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_mid_out", 32'(op_valid), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    op_ready = 1'b1;
    #1;
    chk("rst_mid_op_valid", 32'(op_valid),    32'd0);
    chk("rst_mid_opcode",   32'(op_opcode),   32'd0);
    chk("rst_mid_a",        32'(op_a),        32'd0);
    chk("rst_mid_b",        32'(op_b),        32'd0);
    chk("rst_mid_ready",    32'(instr_ready), 32'd1);
    apply_vec(after_reset);

    @(negedge clock);
    @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb_pops",    32'(pops),      32'(pushes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
